// File: rtl/flag_ctrl_pkg.sv
// Shared encodings for the Z/V/N flag unit:
// opcodes, branch condition codes, flag bit positions, FSM states.
package flag_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OV     = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Which of {Z,V,N} an opcode writes.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dff.sv
// Bank of flops with per-bit write enable and async active-low reset.
// Ports: clk, rst_n, wen[W], d[W] in; q[W] out.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (wen[i]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/flag_ctrl_cond_eval.sv
// Branch condition evaluator over {Z,V,N}.
// Ports: flags[2:0], ccc[2:0] in; taken out.
module cond_eval
  import flag_ctrl_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] ccc,
  output logic       taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = flags[FLAG_Z];
  assign w_v = flags[FLAG_V];
  assign w_n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:     taken = !w_z;
      CC_EQ:     taken = w_z;
      CC_GT:     taken = !w_z && !w_n;
      CC_LT:     taken = w_n;
      CC_GE:     taken = w_z || (!w_z && !w_n);
      CC_LE:     taken = w_n || w_z;
      CC_OV:     taken = w_v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// Z/V/N flag state, branch resolution and flag RAW hazard handling.
// Ports: clk, rst(n), ex_*, id_*, flush in; flags_out, br_*, stall out.
module flag_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter bit FORWARD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic [2:0] ex_flags,
  input  logic       id_br_valid,
  input  logic [2:0] id_ccc,
  input  logic       flush,
  output logic [2:0] flags_out,
  output logic       br_resolved,
  output logic       br_taken,
  output logic       stall
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ccc;
  logic [2:0] w_ccc_nxt;
  logic [2:0] w_mask;
  logic       w_wr;
  logic [2:0] w_eff;
  logic [2:0] w_sel_flags;
  logic [2:0] w_sel_ccc;
  logic       w_taken;

  // A flushed EX instruction must not commit flags.
  assign w_mask = (ex_valid && !flush) ? flag_mask(ex_opcode) : 3'b000;
  assign w_wr   = |w_mask;

  dff #(.W(3)) u_flags (
    .clk   (clk),
    .rst_n (rst),
    .wen   (w_mask),
    .d     (ex_flags),
    .q     (flags_out)
  );

  assign w_eff = FORWARD ? ((ex_flags & w_mask) | (flags_out & ~w_mask))
                         : flags_out;

  // WAIT resolves on the committed (pre-edge) flags.
  assign w_sel_flags = (r_state == S_WAIT) ? flags_out : w_eff;
  assign w_sel_ccc   = (r_state == S_WAIT) ? r_ccc : id_ccc;

  cond_eval u_cond (
    .flags (w_sel_flags),
    .ccc   (w_sel_ccc),
    .taken (w_taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ccc   <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_ccc   <= w_ccc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ccc_nxt   = r_ccc;
    stall       = 1'b0;
    br_resolved = 1'b0;
    br_taken    = 1'b0;
    if (!rst) begin
      w_state_nxt = S_IDLE;
    end else if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (id_br_valid) begin
            if (w_wr && !FORWARD && id_ccc != CC_UNCOND) begin
              stall       = 1'b1;
              w_ccc_nxt   = id_ccc;
              w_state_nxt = S_WAIT;
            end else begin
              br_resolved = 1'b1;
              br_taken    = w_taken;
            end
          end
        end
        S_WAIT: begin
          br_resolved = 1'b1;
          br_taken    = w_taken;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_ctrl.sv
// Self-checking bench for flag_ctrl, both FORWARD settings side by side.
// Directed plan steps followed by random traffic against a reference model.
module tb_flag_ctrl;

  logic       clk;
  logic       rst;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic [2:0] ex_flags;
  logic       id_br_valid;
  logic [2:0] id_ccc;
  logic       flush;

  logic [2:0] flags0, flags1;
  logic       res0, res1, tk0, tk1, st0, st1;

  int checks = 0;
  int errors = 0;

  logic [2:0] m_flags;
  bit         m_pend;
  logic [2:0] m_pccc;

  flag_ctrl #(.FORWARD(1'b0)) u0 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_flags(ex_flags), .id_br_valid(id_br_valid), .id_ccc(id_ccc),
    .flush(flush), .flags_out(flags0), .br_resolved(res0),
    .br_taken(tk0), .stall(st0)
  );

  flag_ctrl #(.FORWARD(1'b1)) u1 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_flags(ex_flags), .id_br_valid(id_br_valid), .id_ccc(id_ccc),
    .flush(flush), .flags_out(flags1), .br_resolved(res1),
    .br_taken(tk1), .stall(st1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [2:0] mask_of(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1) return 3'b111;
    if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
    return 3'b000;
  endfunction

  function automatic bit cond(input logic [2:0] f, input logic [2:0] c);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs,
                     input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ev, input logic [3:0] op,
                       input logic [2:0] ef, input bit bv,
                       input logic [2:0] cc, input bit fl);
    ex_valid    = ev;
    ex_opcode   = op;
    ex_flags    = ef;
    id_br_valid = bv;
    id_ccc      = cc;
    flush       = fl;
  endtask

  // Check all outputs against the model, then clock and advance the model.
  task automatic cycle(input string tag);
    logic [2:0] m, eff, npc;
    bit er0, et0, es0, er1, et1, np;
    #2;
    m   = (ex_valid && !flush) ? mask_of(ex_opcode) : 3'b000;
    eff = (ex_flags & m) | (m_flags & ~m);
    er1 = id_br_valid && !flush;
    et1 = er1 && cond(eff, id_ccc);
    np  = 1'b0; npc = m_pccc;
    er0 = 1'b0; et0 = 1'b0; es0 = 1'b0;
    if (m_pend) begin
      er0 = !flush;
      et0 = er0 && cond(m_flags, m_pccc);
    end else if (!flush && id_br_valid) begin
      if (m != 3'b000 && id_ccc != 3'b111) begin
        es0 = 1'b1; np = 1'b1; npc = id_ccc;
      end else begin
        er0 = 1'b1; et0 = cond(m_flags, id_ccc);
      end
    end
    chk({tag, ".flags0"}, flags0, m_flags);
    chk({tag, ".flags1"}, flags1, m_flags);
    chk({tag, ".stall0"}, st0, es0);
    chk({tag, ".stall1"}, st1, 1'b0);
    chk({tag, ".res0"}, res0, er0);
    chk({tag, ".res1"}, res1, er1);
    if (er0) chk({tag, ".taken0"}, tk0, et0);
    if (er1) chk({tag, ".taken1"}, tk1, et1);
    @(posedge clk);
    m_flags = eff;
    m_pend  = np;
    m_pccc  = npc;
    #1;
  endtask

  initial begin
    m_flags = 3'b000; m_pend = 1'b0; m_pccc = 3'b000;
    rst = 1'b0;
    drive(0, 4'd0, 3'b000, 0, 3'd0, 0);

    // 1: reset holds outputs low even with a branch presented
    @(posedge clk); #1;
    drive(1, 4'd0, 3'b111, 1, 3'd1, 0);
    @(posedge clk); #1;
    #2;
    chk("rst.flags0", flags0, 3'b000);
    chk("rst.stall0", st0, 1'b0);
    chk("rst.res0", res0, 1'b0);
    chk("rst.res1", res1, 1'b0);
    rst = 1'b1;
    drive(0, 4'd0, 3'b000, 1, 3'd1, 0);
    #1;
    chk("rst.eq_res", res0, 1'b1);
    chk("rst.eq_taken", tk0, 1'b0);
    cycle("t1");

    // 2: partial write keeps V and N
    drive(1, 4'd1, 3'b111, 0, 3'd0, 0); cycle("t2a");
    drive(1, 4'd2, 3'b000, 0, 3'd0, 0); cycle("t2b");
    drive(0, 4'd0, 3'b000, 0, 3'd0, 0);
    #1; chk("t2.flags", flags0, 3'b011);
    cycle("t2c");

    // 3/4: hazard branch EQ after ADD Z=1
    drive(1, 4'd0, 3'b100, 1, 3'd1, 0);
    #1;
    chk("t3.stall", st0, 1'b1);
    chk("t3.res0", res0, 1'b0);
    chk("t4.res1", res1, 1'b1);
    chk("t4.taken1", tk1, 1'b1);
    chk("t4.stall1", st1, 1'b0);
    cycle("t3a");
    drive(0, 4'd0, 3'b000, 1, 3'd1, 0);
    #1;
    chk("t3.stall_c1", st0, 1'b0);
    chk("t3.res_c1", res0, 1'b1);
    chk("t3.taken_c1", tk0, 1'b1);
    cycle("t3b");

    // 5: flush in WAIT aborts and suppresses a SUB write
    drive(1, 4'd0, 3'b000, 1, 3'd0, 0); cycle("t5a");
    drive(1, 4'd1, 3'b111, 1, 3'd0, 1);
    #1; chk("t5.res_flush", res0, 1'b0);
    cycle("t5b");
    drive(0, 4'd0, 3'b000, 1, 3'd0, 0);
    #1;
    chk("t5.flags", flags0, 3'b000);
    chk("t5.idle_res", res0, 1'b1);
    cycle("t5c");

    // reset during WAIT aborts the pending branch
    drive(1, 4'd1, 3'b101, 1, 3'd3, 0); cycle("rw_a");
    drive(0, 4'd0, 3'b000, 1, 3'd3, 0);
    rst = 1'b0; m_flags = 3'b000; m_pend = 1'b0;
    #2;
    chk("rw.flags", flags0, 3'b000);
    chk("rw.res", res0, 1'b0);
    chk("rw.stall", st0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 4'd0, 3'b000, 0, 3'd0, 0);
    cycle("rw_b");

    // 6: sweep every ccc over every flag value
    for (int f = 0; f < 8; f++) begin
      drive(1, 4'd0, f[2:0], 0, 3'd0, 0); cycle("sw_set");
      for (int c = 0; c < 8; c++) begin
        drive(0, 4'd0, 3'b000, 1, c[2:0], 0);
        cycle("sweep");
      end
    end
    drive(1, 4'd0, 3'b000, 1, 3'd7, 0);
    #1;
    chk("t6.uncond_stall", st0, 1'b0);
    chk("t6.uncond_res", res0, 1'b1);
    chk("t6.uncond_taken", tk0, 1'b1);
    cycle("t6u");

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
